// File: rtl/yousei_io_pkg.sv
// Shared definitions for the IN/OUT responder (unidade_entrada_saida).
// Contents: responder FSM state type, I/O opcodes decoded by the control
// unit, and the Mem2Reg select value that routes InData to the register file.
package yousei_io_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_WAIT_PRESS   = 2'd1,
    ST_WAIT_RELEASE = 2'd2,
    ST_DONE         = 2'd3
  } io_state_t;

  localparam logic [5:0] OP_IN      = 6'b001000;
  localparam logic [5:0] OP_OUT     = 6'b001001;
  localparam logic [1:0] MEM2REG_IO = 2'b01;

endpackage

// File: rtl/debounce_botao.sv
// Confirm-button conditioner: 2-FF synchronizer, polarity normalization
// (pressed = 1) and a stability-counter debouncer with edge outputs.
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_btn_raw       raw asynchronous button level
//   o_rise / o_fall single-cycle strobes, valid in the cycle before the
//                   debounced level flips (consumed on that same edge)
// Press-to-flip latency: 2 + DEBOUNCE_CYCLES edges.
module debounce_botao
  import yousei_io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn_raw,
  output logic o_rise,
  output logic o_fall
);

  localparam int unsigned    CW           = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST     = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic           RELEASED_RAW = BTN_ACTIVE_LOW;

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic [CW-1:0] r_cnt;
  logic          w_synced;
  logic          w_diff;
  logic          w_flip;

  assign w_synced = r_sync2 ^ RELEASED_RAW;
  assign w_diff   = (w_synced != r_level);
  assign w_flip   = w_diff && (r_cnt == CNT_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= RELEASED_RAW;
      r_sync2 <= RELEASED_RAW;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn_raw;
      r_sync2 <= r_sync1;
      if (w_flip) begin
        r_level <= w_synced;
        r_cnt   <= '0;
      end else if (w_diff) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_rise = w_flip &  w_synced;
  assign o_fall = w_flip & ~w_synced;

endmodule

// File: rtl/unidade_entrada_saida.sv
// IN/OUT responder between the control unit/datapath and the board I/O.
// IN (Halt=1): stalls until the operator presses and releases the confirm
// button; Switches are captured (zero-extended) on the debounced press and
// offered on InData, with InReady marking the register-write cycle.
// OUT (OpIO=1, Halt=0): Display <= OutData, OutStrobe pulses next cycle.
// Optional macro YOUSEI_IO_ECHO_EN: on IN completion Display also shows the
// accepted value (OutStrobe pulses); undefined, Display changes only on OUT.
// Ports:
//   Clock, Reset (async, active-low)
//   OpIO, Halt, OutData          from control unit / register file
//   Switches, ConfirmBtn         board inputs
//   Stall (combinational), InData, InReady, Display, OutStrobe, WaitingInput
module unidade_entrada_saida
  import yousei_io_pkg::*;
#(
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned SW_W            = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              OpIO,
  input  logic              Halt,
  input  logic [DATA_W-1:0] OutData,
  input  logic [SW_W-1:0]   Switches,
  input  logic              ConfirmBtn,
  output logic              Stall,
  output logic [DATA_W-1:0] InData,
  output logic              InReady,
  output logic [DATA_W-1:0] Display,
  output logic              OutStrobe,
  output logic              WaitingInput
);

  io_state_t         r_state;
  logic [DATA_W-1:0] r_in_data;
  logic [DATA_W-1:0] r_display;
  logic              r_in_ready;
  logic              r_out_strobe;
  logic              w_rise;
  logic              w_fall;

  debounce_botao #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
  ) u_debounce (
    .i_clk     (Clock),
    .i_rst_n   (Reset),
    .i_btn_raw (ConfirmBtn),
    .o_rise    (w_rise),
    .o_fall    (w_fall)
  );

  // The debouncer runs in every state; edges are only acted on while
  // waiting, so a press already held at IN time needs release + re-press.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state      <= ST_IDLE;
      r_in_data    <= '0;
      r_display    <= '0;
      r_in_ready   <= 1'b0;
      r_out_strobe <= 1'b0;
    end else begin
      r_in_ready   <= 1'b0;
      r_out_strobe <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (Halt) begin
            r_state <= ST_WAIT_PRESS;
          end else if (OpIO) begin
            r_display    <= OutData;
            r_out_strobe <= 1'b1;
          end
        end
        ST_WAIT_PRESS: begin
          if (w_rise) begin
            r_in_data <= DATA_W'(Switches);
            r_state   <= ST_WAIT_RELEASE;
          end
        end
        ST_WAIT_RELEASE: begin
          if (w_fall) begin
            r_state    <= ST_DONE;
            r_in_ready <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
`ifdef YOUSEI_IO_ECHO_EN
          r_display    <= r_in_data;
          r_out_strobe <= 1'b1;
`endif
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign Stall        = ((r_state == ST_IDLE) && Halt) ||
                        (r_state == ST_WAIT_PRESS) ||
                        (r_state == ST_WAIT_RELEASE);
  assign WaitingInput = (r_state == ST_WAIT_PRESS) || (r_state == ST_WAIT_RELEASE);
  assign InData       = r_in_data;
  assign InReady      = r_in_ready;
  assign Display      = r_display;
  assign OutStrobe    = r_out_strobe;

endmodule

// File: tb/tb_unidade_entrada_saida.sv
module tb_unidade_entrada_saida;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned SW_W   = 16;
  localparam int unsigned DB     = 4;

  logic              Clock = 1'b0;
  logic              Reset;
  logic              OpIO;
  logic              Halt;
  logic [DATA_W-1:0] OutData;
  logic [SW_W-1:0]   Switches;
  logic              ConfirmBtn;
  logic              Stall;
  logic [DATA_W-1:0] InData;
  logic              InReady;
  logic [DATA_W-1:0] Display;
  logic              OutStrobe;
  logic              WaitingInput;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DATA_W-1:0] exp_disp_q[$];
  logic [DATA_W-1:0] exp_in_q[$];
  logic [DATA_W-1:0] disp_model;
  logic [DATA_W-1:0] mon_exp;

  always #5 Clock = ~Clock;

  unidade_entrada_saida #(
    .DATA_W          (DATA_W),
    .SW_W            (SW_W),
    .DEBOUNCE_CYCLES (DB),
    .BTN_ACTIVE_LOW  (1'b1)
  ) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .OpIO         (OpIO),
    .Halt         (Halt),
    .OutData      (OutData),
    .Switches     (Switches),
    .ConfirmBtn   (ConfirmBtn),
    .Stall        (Stall),
    .InData       (InData),
    .InReady      (InReady),
    .Display      (Display),
    .OutStrobe    (OutStrobe),
    .WaitingInput (WaitingInput)
  );

  // Scoreboard side: every strobe/ready pulse must match a queued expectation.
  always @(negedge Clock) begin
    if (Reset === 1'b1) begin
      if (OutStrobe === 1'b1) begin
        n_tests++;
        if (exp_disp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_strobe_unexpected: OutStrobe=1 Display=%h, required no strobe", Display);
        end else begin
          mon_exp = exp_disp_q.pop_front();
          if (Display !== mon_exp) begin
            n_fail++;
            $display("FAIL sb_display: got %h, expected %h", Display, mon_exp);
          end
        end
      end
      if (InReady === 1'b1) begin
        n_tests++;
        if (exp_in_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_inready_unexpected: InReady=1 InData=%h, required no pulse", InData);
        end else begin
          mon_exp = exp_in_q.pop_front();
          if (InData !== mon_exp) begin
            n_fail++;
            $display("FAIL sb_indata: got %h, expected %h", InData, mon_exp);
          end
        end
        n_tests++;
        if (Stall !== 1'b0) begin
          n_fail++;
          $display("FAIL sb_stall_in_done: got %b, expected 0", Stall);
        end
      end
    end
  end

  task automatic edge1();
    @(posedge Clock);
    #1;
  endtask

  // Returns the number of edges until InReady is seen, or -1 on timeout.
  task automatic wait_ready(input int limit, output int cycles);
    cycles = -1;
    for (int i = 1; i <= limit; i++) begin
      @(posedge Clock);
      @(negedge Clock);
      if (InReady === 1'b1) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic push_echo(input logic [DATA_W-1:0] v);
`ifdef YOUSEI_IO_ECHO_EN
    exp_disp_q.push_back(v);
    disp_model = v;
`else
    if (v === 'x) disp_model = v;
`endif
  endtask

  task automatic test_reset();
    Reset = 1'b1; OpIO = 1'b0; Halt = 1'b1; OutData = '0; Switches = '0; ConfirmBtn = 1'b1;
    #1 Reset = 1'b0;
    #1;
    n_tests++; if (Stall !== 1'b1)       begin n_fail++; $display("FAIL rst_stall_halt: got %b, expected 1", Stall); end
    n_tests++; if (InData !== '0)        begin n_fail++; $display("FAIL rst_indata: got %h, expected 0", InData); end
    n_tests++; if (Display !== '0)       begin n_fail++; $display("FAIL rst_display: got %h, expected 0", Display); end
    n_tests++; if (InReady !== 1'b0)     begin n_fail++; $display("FAIL rst_inready: got %b, expected 0", InReady); end
    n_tests++; if (OutStrobe !== 1'b0)   begin n_fail++; $display("FAIL rst_outstrobe: got %b, expected 0", OutStrobe); end
    n_tests++; if (WaitingInput !== 1'b0) begin n_fail++; $display("FAIL rst_waiting: got %b, expected 0", WaitingInput); end
    Halt = 1'b0;
    #1;
    n_tests++; if (Stall !== 1'b0)       begin n_fail++; $display("FAIL rst_stall_nohalt: got %b, expected 0", Stall); end
    repeat (3) edge1();
    Reset = 1'b1;
    disp_model = '0;
  endtask

  task automatic test_out();
    edge1();
    OpIO = 1'b1; OutData = 32'h0000002A;
    exp_disp_q.push_back(32'h0000002A); disp_model = 32'h0000002A;
    @(negedge Clock);
    n_tests++; if (Stall !== 1'b0) begin n_fail++; $display("FAIL out_stall: got %b, expected 0", Stall); end
    edge1();
    OpIO = 1'b0; OutData = 32'hDEADBEEF;
    @(negedge Clock);
    n_tests++; if (Display !== 32'h0000002A) begin n_fail++; $display("FAIL out_display: got %h, expected 0000002a", Display); end
    @(negedge Clock);
    n_tests++; if (OutStrobe !== 1'b0) begin n_fail++; $display("FAIL out_strobe_width: got %b, expected 0", OutStrobe); end
    n_tests++; if (Display !== 32'h0000002A) begin n_fail++; $display("FAIL out_display_hold: got %h, expected 0000002a", Display); end
    n_tests++; if (exp_disp_q.size() != 0) begin n_fail++; $display("FAIL out_queue: got %0d pending, expected 0", exp_disp_q.size()); end
  endtask

  task automatic test_out_hold();
    edge1();
    OpIO = 1'b1;
    for (int k = 0; k < 3; k++) begin
      OutData = 32'h00000100 + DATA_W'(k);
      exp_disp_q.push_back(OutData);
      edge1();
    end
    OpIO = 1'b0;
    disp_model = 32'h00000102;
    repeat (2) @(negedge Clock);
    n_tests++; if (exp_disp_q.size() != 0) begin n_fail++; $display("FAIL hold_queue: got %0d pending, expected 0", exp_disp_q.size()); end
    n_tests++; if (Display !== 32'h00000102) begin n_fail++; $display("FAIL hold_display: got %h, expected 00000102", Display); end
  endtask

  task automatic test_in();
    int c;
    edge1();
    Switches = 16'h00FF; Halt = 1'b1; OpIO = 1'b1;   // OpIO with Halt: IN only
    @(negedge Clock);
    n_tests++; if (Stall !== 1'b1) begin n_fail++; $display("FAIL in_stall_first: got %b, expected 1", Stall); end
    for (int i = 0; i < 10; i++) begin
      edge1();
      @(negedge Clock);
      n_tests++; if (Stall !== 1'b1 || WaitingInput !== 1'b1) begin
        n_fail++; $display("FAIL in_wait_state: stall=%b waiting=%b, expected 1/1", Stall, WaitingInput);
      end
    end
    edge1();
    ConfirmBtn = 1'b0;
    exp_in_q.push_back(32'h000000FF);
    repeat (5) @(posedge Clock);
    @(negedge Clock);
    n_tests++; if (InData !== '0) begin n_fail++; $display("FAIL in_not_early: got %h, expected 0", InData); end
    @(posedge Clock);
    @(negedge Clock);
    n_tests++; if (InData !== 32'h000000FF) begin n_fail++; $display("FAIL in_capture_latency: got %h, expected 000000ff", InData); end
    n_tests++; if (Stall !== 1'b1) begin n_fail++; $display("FAIL in_stall_release_wait: got %b, expected 1", Stall); end
    edge1();
    Switches = 16'hABCD;
    edge1();
    ConfirmBtn = 1'b1;
    wait_ready(20, c);
    n_tests++; if (c != 2 + DB) begin n_fail++; $display("FAIL in_ready_latency: got %0d, expected %0d", c, 2 + DB); end
    push_echo(32'h000000FF);
    edge1();
    Halt = 1'b0; OpIO = 1'b0;
    @(negedge Clock);
    n_tests++; if (InReady !== 1'b0) begin n_fail++; $display("FAIL in_ready_width: got %b, expected 0", InReady); end
    n_tests++; if (Display !== disp_model) begin n_fail++; $display("FAIL in_display: got %h, expected %h", Display, disp_model); end
    n_tests++; if (InData !== 32'h000000FF) begin n_fail++; $display("FAIL in_switch_change: got %h, expected 000000ff", InData); end
  endtask

  task automatic test_bounce();
    int c;
    edge1();
    Switches = 16'h5555; Halt = 1'b1;
    repeat (2) edge1();
    for (int k = 0; k < 3; k++) begin
      ConfirmBtn = 1'b0; repeat (2) edge1();
      ConfirmBtn = 1'b1; repeat (2) edge1();
    end
    for (int i = 0; i < 10; i++) begin
      edge1();
      @(negedge Clock);
      n_tests++; if (Stall !== 1'b1 || WaitingInput !== 1'b1 || InData !== 32'h000000FF) begin
        n_fail++; $display("FAIL bounce_no_capture: stall=%b waiting=%b indata=%h, expected 1/1/000000ff", Stall, WaitingInput, InData);
      end
    end
    edge1();
    ConfirmBtn = 1'b0;
    exp_in_q.push_back(32'h00005555);
    repeat (8) edge1();
    ConfirmBtn = 1'b1;
    wait_ready(20, c);
    n_tests++; if (c != 2 + DB) begin n_fail++; $display("FAIL bounce_ready: got %0d, expected %0d", c, 2 + DB); end
    push_echo(32'h00005555);
    edge1();
    Halt = 1'b0;
    @(negedge Clock);
    n_tests++; if (Display !== disp_model) begin n_fail++; $display("FAIL bounce_display: got %h, expected %h", Display, disp_model); end
  endtask

  task automatic test_held();
    int c;
    edge1();
    Switches = 16'h1111; ConfirmBtn = 1'b0;
    for (int i = 0; i < 8; i++) begin
      edge1();
      @(negedge Clock);
      n_tests++; if (Stall !== 1'b0) begin n_fail++; $display("FAIL held_idle_stall: got %b, expected 0", Stall); end
    end
    edge1();
    Halt = 1'b1;
    for (int i = 0; i < 10; i++) begin
      edge1();
      @(negedge Clock);
      n_tests++; if (InData !== 32'h00005555) begin n_fail++; $display("FAIL held_no_capture: got %h, expected 00005555", InData); end
    end
    edge1();
    ConfirmBtn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      edge1();
      @(negedge Clock);
      n_tests++; if (InData !== 32'h00005555 || Stall !== 1'b1) begin
        n_fail++; $display("FAIL held_release: indata=%h stall=%b, expected 00005555/1", InData, Stall);
      end
    end
    edge1();
    Switches = 16'h2222; ConfirmBtn = 1'b0;
    exp_in_q.push_back(32'h00002222);
    repeat (2 + DB) @(posedge Clock);
    @(negedge Clock);
    n_tests++; if (InData !== 32'h00002222) begin n_fail++; $display("FAIL held_capture: got %h, expected 00002222", InData); end
    edge1();
    Switches = 16'h3333;
    edge1();
    ConfirmBtn = 1'b1;
    wait_ready(20, c);
    n_tests++; if (c != 2 + DB) begin n_fail++; $display("FAIL held_ready: got %0d, expected %0d", c, 2 + DB); end
    push_echo(32'h00002222);
    edge1();
    Halt = 1'b0;
    @(negedge Clock);
    n_tests++; if (Display !== disp_model) begin n_fail++; $display("FAIL held_display: got %h, expected %h", Display, disp_model); end
  endtask

  task automatic test_echo();
    int c;
    edge1();
    Switches = 16'h1234; Halt = 1'b1;
    repeat (2) edge1();
    ConfirmBtn = 1'b0;
    exp_in_q.push_back(32'h00001234);
    repeat (8) edge1();
    ConfirmBtn = 1'b1;
    wait_ready(20, c);
    n_tests++; if (c != 2 + DB) begin n_fail++; $display("FAIL echo_ready: got %0d, expected %0d", c, 2 + DB); end
    push_echo(32'h00001234);
    edge1();
    Halt = 1'b0;
    @(negedge Clock);
    n_tests++; if (Display !== disp_model) begin n_fail++; $display("FAIL echo_display: got %h, expected %h", Display, disp_model); end
    n_tests++; if (exp_disp_q.size() != 0 || exp_in_q.size() != 0) begin
      n_fail++; $display("FAIL echo_queue: got %0d/%0d pending, expected 0/0", exp_disp_q.size(), exp_in_q.size());
    end
  endtask

  task automatic test_reset_mid();
    edge1();
    Switches = 16'h0F0F; Halt = 1'b1;
    repeat (2) edge1();
    ConfirmBtn = 1'b0;
    repeat (8) edge1();
    @(negedge Clock);
    n_tests++; if (WaitingInput !== 1'b1 || InData !== 32'h00000F0F) begin
      n_fail++; $display("FAIL mid_pre: waiting=%b indata=%h, expected 1/00000f0f", WaitingInput, InData);
    end
    edge1();
    Reset = 1'b0;
    #1;
    n_tests++; if (Display !== '0)        begin n_fail++; $display("FAIL mid_display: got %h, expected 0", Display); end
    n_tests++; if (InData !== '0)         begin n_fail++; $display("FAIL mid_indata: got %h, expected 0", InData); end
    n_tests++; if (WaitingInput !== 1'b0) begin n_fail++; $display("FAIL mid_waiting: got %b, expected 0", WaitingInput); end
    n_tests++; if (Stall !== 1'b1)        begin n_fail++; $display("FAIL mid_stall_halt: got %b, expected 1", Stall); end
    Halt = 1'b0;
    #1;
    n_tests++; if (Stall !== 1'b0)        begin n_fail++; $display("FAIL mid_stall_nohalt: got %b, expected 0", Stall); end
    ConfirmBtn = 1'b1;
    repeat (3) edge1();
    Reset = 1'b1;
    disp_model = '0;
    edge1();
    OpIO = 1'b1; OutData = 32'h00000077;
    exp_disp_q.push_back(32'h00000077);
    edge1();
    OpIO = 1'b0;
    repeat (2) @(negedge Clock);
    n_tests++; if (exp_disp_q.size() != 0 || Display !== 32'h00000077) begin
      n_fail++; $display("FAIL mid_post_out: pending=%0d display=%h, expected 0/00000077", exp_disp_q.size(), Display);
    end
  endtask

  initial begin
    test_reset();
    test_out();
    test_out_hold();
    test_in();
    test_bounce();
    test_held();
    test_echo();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
